// File: rtl/fc_neuron_bank.sv
// fc_neuron_bank: NUM_NEURONS fixed-point neurons share one activation stream and emit results serially.
// Optional build macro FC_NEURON_BANK_RELU_EN clamps results at zero; ROM_PROFILE picks built-in test ROM tables.

module ROM_neuron #(
    parameter int WORD_SIZE     = 16,
    parameter int N_SIZE        = 8,
    parameter int ADDR_W        = 3,
    parameter int INPUT_LENGTH  = 4,
    parameter int LAYER_NUMBER  = 1,
    parameter int NEURON_NUMBER = 0,
    parameter int NEURON_TYPE   = 1,
    parameter int ROM_PROFILE   = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [WORD_SIZE-1:0] data_o
);
    logic [WORD_SIZE-1:0] data_q;
    logic [WORD_SIZE-1:0] data_d;

    // Built-in test tables for layer 1 fully-connected neurons; trained contents replace these
    function automatic logic [WORD_SIZE-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [WORD_SIZE-1:0] one_w;
        logic [WORD_SIZE-1:0] half_w;
        logic [WORD_SIZE-1:0] w;
        logic                 is_bias;
        one_w   = WORD_SIZE'(1) << N_SIZE;
        half_w  = WORD_SIZE'(1) << (N_SIZE - 1);
        is_bias = (a == ADDR_W'(INPUT_LENGTH));
        w       = '0;
        if (NEURON_TYPE == 1 && LAYER_NUMBER == 1) begin
            case (ROM_PROFILE)
                0: w = is_bias ? half_w : one_w;
                1: w = is_bias ? '0 : ((NEURON_NUMBER % 2 == 0) ? {1'b0, {(WORD_SIZE-1){1'b1}}}
                                                                 : {1'b1, {(WORD_SIZE-1){1'b0}}});
                2: w = is_bias ? '0 : ((a == '0) ? (WORD_SIZE'(0) - half_w) : (WORD_SIZE'(a) << N_SIZE));
                default: w = '0;
            endcase
        end else begin
            w = '0;
        end
        return w;
    endfunction

    // Table lookup feeding the read register
    always_comb begin
        data_d = rom_word(addr_i);
    end

    // One-cycle read latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

module fc_neuron_bank #(
    parameter int WORD_SIZE    = 16,
    parameter int N_SIZE       = 8,
    parameter int INPUT_LENGTH = 4,
    parameter int NUM_NEURONS  = 4,
    parameter int LAYER_NUMBER = 1,
    parameter int ROM_PROFILE  = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [WORD_SIZE-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [WORD_SIZE-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 out_last_o
);
    localparam int ADDR_W = $clog2(INPUT_LENGTH + 1);
    localparam int SEL_W  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int PROD_W = 2 * WORD_SIZE;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam logic [SEL_W-1:0]         LAST_SEL = SEL_W'(NUM_NEURONS - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_BIAS   = 2'd1,
        ST_FINAL  = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          idx_q, idx_d, rom_addr_s;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic signed [WORD_SIZE-1:0] mac_data_q, mac_data_d;
    logic                       mac_en_q, mac_en_d;
    logic signed [ACC_W-1:0]    acc_q [NUM_NEURONS];
    logic signed [ACC_W-1:0]    acc_d [NUM_NEURONS];
    logic signed [PROD_W-1:0]   prod_s [NUM_NEURONS];
    logic signed [WORD_SIZE-1:0] rom_data_s [NUM_NEURONS];
    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [WORD_SIZE-1:0]       out_data_q, out_data_d;
    logic                       in_hs_s, out_hs_s;

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_rom
        ROM_neuron #(
            .WORD_SIZE    (WORD_SIZE),
            .N_SIZE       (N_SIZE),
            .ADDR_W       (ADDR_W),
            .INPUT_LENGTH (INPUT_LENGTH),
            .LAYER_NUMBER (LAYER_NUMBER),
            .NEURON_NUMBER(n),
            .NEURON_TYPE  (1),
            .ROM_PROFILE  (ROM_PROFILE)
        ) u_rom (
            .clk_i (clk_i),
            .rst_i (~reset_n_i),
            .addr_i(rom_addr_s),
            .data_o(rom_data_s[n])
        );
    end

    // Drop the fractional bits (floor), clamp to the word range, optionally rectify
    function automatic logic [WORD_SIZE-1:0] shape_result(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic [WORD_SIZE-1:0]    sat;
        shifted = acc >>> N_SIZE;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[WORD_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[WORD_SIZE-1:0];
        end else begin
            sat = shifted[WORD_SIZE-1:0];
        end
`ifdef FC_NEURON_BANK_RELU_EN
        sat = sat[WORD_SIZE-1] ? '0 : sat;
`endif
        return sat;
    endfunction

    // Sequencer, MAC/bias accumulation and next values of the output registers
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        mac_data_d = mac_data_q;
        mac_en_d   = 1'b0;
        in_hs_s    = in_valid_i & in_ready_q;
        out_hs_s   = out_valid_q & out_ready_i;
        rom_addr_s = (state_q == ST_BIAS) ? ADDR_W'(INPUT_LENGTH) : idx_q;

        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod_s[n] = PROD_W'(mac_data_q) * PROD_W'(rom_data_s[n]);
            if (mac_en_q) begin
                acc_d[n] = acc_q[n] + ACC_W'(prod_s[n]);
            end else if (state_q == ST_FINAL) begin
                acc_d[n] = acc_q[n] + (ACC_W'(rom_data_s[n]) <<< N_SIZE);
            end else begin
                acc_d[n] = acc_q[n];
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (in_hs_s) begin
                    mac_data_d = $signed(in_data_i);
                    mac_en_d   = 1'b1;
                    idx_d      = idx_q + ADDR_W'(1);
                    state_d    = (idx_q == ADDR_W'(INPUT_LENGTH - 1)) ? ST_BIAS : ST_ACCUM;
                end else begin
                    mac_en_d = 1'b0;
                end
            end
            ST_BIAS:  state_d = ST_FINAL;
            ST_FINAL: state_d = ST_OUTPUT;
            ST_OUTPUT: begin
                if (out_hs_s && sel_q == LAST_SEL) begin
                    state_d = ST_ACCUM;
                    sel_d   = '0;
                    idx_d   = '0;
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        acc_d[n] = '0;
                    end
                end else if (out_hs_s) begin
                    sel_d = sel_q + SEL_W'(1);
                end else begin
                    sel_d = sel_q;
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        // Outputs are registered, so they are derived from the next state
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUTPUT);
        out_last_d  = out_valid_d && (sel_d == LAST_SEL);
        out_data_d  = out_valid_d ? shape_result(acc_d[sel_d]) : '0;
    end

    // All state, datapath and output flops
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_ACCUM;
            idx_q       <= '0;
            sel_q       <= '0;
            mac_data_q  <= '0;
            mac_en_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            mac_data_q  <= mac_data_d;
            mac_en_q    <= mac_en_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_data_o  = out_data_q;
endmodule

// File: doc/fc_neuron_bank.md
# fc_neuron_bank

Sequenced fully-connected layer slice. It holds NUM_NEURONS fixed-point neurons, and each neuron has its own ROM_neuron weight/bias memory. The neurons share one valid/ready input stream carrying an INPUT_LENGTH-word activation vector. The block emits the NUM_NEURONS results as a serial valid/ready output stream. It replaces per-neuron external sequencing with an internal FSM, adds handshakes, back-pressure and saturation, and sits between CNN layers in the inference pipeline.

## Interface
- WORD_SIZE, 16, signed data/weight width
- N_SIZE, 8, fractional bits (Q(WORD_SIZE-N_SIZE).N_SIZE)
- INPUT_LENGTH, 4, words per input vector (≥1)
- NUM_NEURONS, 4, neurons in bank (≥1)
- LAYER_NUMBER, 1, passed to every ROM_neuron; neuron n uses neuron_number=n, neuron_type=1
- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  asynchronous active-low reset
- in_data_i  in  WORD_SIZE  signed activation word
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  bank accepts input word
- out_data_o  out  WORD_SIZE  signed neuron result
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- out_last_o  out  1  marks neuron NUM_NEURONS-1 result

## Operation
- ROM address map per neuron: 0..INPUT_LENGTH-1 = weights, INPUT_LENGTH = bias; address width $clog2(INPUT_LENGTH+1); read latency 1 cycle. ROM reset driven by ~reset_n_i.
- FSM states: ACCUM → BIAS → FINAL → OUTPUT → ACCUM.
- ACCUM: in_ready_o=1. Each handshake (in_valid_i & in_ready_o) presents address idx to all ROMs and registers in_data_i plus a mac_en flag; idx increments. Handshake with idx=INPUT_LENGTH-1 → BIAS. idle cycles (in_valid_i=0) hold idx and leave accumulators unchanged.
- MAC stage (cycle after each handshake): acc[n] += data_d × weight[n]. Full-precision product 2·WORD_SIZE bits, 2·N_SIZE frac bits. Accumulator width 2·WORD_SIZE+$clog2(INPUT_LENGTH+1), no internal overflow.
- BIAS (1 cycle): address INPUT_LENGTH presented; last MAC performed; in_ready_o=0.
- FINAL (1 cycle): acc[n] += sign-extended bias <<< N_SIZE.
- OUTPUT: sel counts 0..NUM_NEURONS-1. out_data_o = sat(acc[sel] >>> N_SIZE), arithmetic shift (truncation toward −∞), saturated to [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1]. out_last_o = (sel==NUM_NEURONS-1). Each output handshake advances sel. The last handshake clears all accumulators, idx and sel → ACCUM.
- out_valid_o=1 only in OUTPUT. Data, last and sel are held stable while out_ready_i=0.

## Timing
- Reset (async assert, sync deassert by system): state ACCUM, idx=0, sel=0, acc=0, mac_en=0. in_ready_o=0 while reset_n_i low, then 1. out_valid_o=0, out_last_o=0, out_data_o=0.
- Last input handshake at cycle t: BIAS at t+1, FINAL at t+2, out_valid_o=1 with neuron 0 at t+3.
- Throughput with out_ready_i=1: INPUT_LENGTH + 2 + NUM_NEURONS cycles per vector.
- No input accepted during BIAS, FINAL, OUTPUT. Input is never dropped: a word presented then stays pending until ACCUM.
- First input handshake is allowed in the cycle after the last output handshake.
- Reset mid-vector or mid-output: partial state discarded immediately; no output emitted for that vector.

## Configuration
- FC_NEURON_BANK_RELU_EN defined: out_data_o = max(0, saturated result); ReLU is applied after saturation and uses no extra cycle.
- Undefined: signed saturated result passed unchanged.

## Test plan
All scenarios use WORD_SIZE=16, N_SIZE=8, INPUT_LENGTH=4, NUM_NEURONS=2, with test ROMs.
- Basic: all weights 0x0100 and bias 0x0080; inputs 0x0100 ×4 → two outputs of 0x0480; out_last_o on the second only; out_valid_o rises 3 cycles after the last input handshake.
- Saturation: weights 0x7FFF and inputs 0x7FFF → 0x7FFF. Neuron 1 weights 0x8000 → 0x8000, or 0x0000 with RELU_EN.
- Negative/truncation: weight 0xFF80 (−0.5), one input 0x0001, others 0, bias 0 → 0xFFFF (truncation toward −∞). With RELU_EN → 0x0000.
- Back-pressure and gaps: in_valid_i toggles every cycle and out_ready_i is low for 5 cycles on neuron 0 → same values as Basic; out_data_o stable while stalled; in_ready_o=0 throughout OUTPUT.
- Back-to-back vectors: second vector (inputs 0x0200) presented during OUTPUT → accepted only after the final output handshake; results 0x0880 with no accumulation carried over from vector 1.
- Reset mid-operation: assert reset_n_i after 2 input words → out_valid_o=0 and in_ready_o=0 immediately. A fresh 4-word vector after reset yields exactly the Basic result.
